// File: rtl/leaky_relu_pipe.sv
// leaky_relu_pipe: two-stage ReLU / leaky ReLU / identity with round-to-nearest, saturation and sticky overflow flag
module leaky_relu_pipe #(
   parameter int DATA_IN_0_PRECISION_0       = 8,
   parameter int DATA_IN_0_PRECISION_1       = 4,
   parameter int DATA_IN_0_PARALLELISM_DIM_0 = 4,
   parameter int DATA_IN_0_PARALLELISM_DIM_1 = 1,
   parameter int DATA_OUT_0_PRECISION_0      = 8,
   parameter int DATA_OUT_0_PRECISION_1      = 4,
   parameter int SLOPE_PRECISION_0           = 8,
   parameter int SLOPE_PRECISION_1           = 7
) (
   input  logic                                                                                    clk,
   input  logic                                                                                    rst,
   input  logic [1:0]                                                                              mode,
   input  logic [SLOPE_PRECISION_0-1:0]                                                            slope,
   input  logic                                                                                    sat_clear,
   input  logic [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1*DATA_IN_0_PRECISION_0-1:0]  data_in_0,
   input  logic                                                                                    data_in_0_valid,
   output logic                                                                                    data_in_0_ready,
   output logic [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1*DATA_OUT_0_PRECISION_0-1:0] data_out_0,
   output logic                                                                                    data_out_0_valid,
   input  logic                                                                                    data_out_0_ready,
   output logic                                                                                    sat_sticky
);
   localparam int N   = DATA_IN_0_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_1;
   localparam int IW  = DATA_IN_0_PRECISION_0;
   localparam int OW  = DATA_OUT_0_PRECISION_0;
   localparam int OFR = DATA_OUT_0_PRECISION_1;
   localparam int SW  = SLOPE_PRECISION_0;
   localparam int SFR = SLOPE_PRECISION_1;
   localparam int PW  = IW + SW;
   localparam int PFR = DATA_IN_0_PRECISION_1 + SFR;
   localparam int K   = PFR > OFR ? PFR - OFR : 0;
   localparam int L   = OFR > PFR ? OFR - PFR : 0;
   localparam int AW  = PW + 1 + L > OW + 1 ? PW + 1 + L : OW + 1;
   localparam logic signed [AW-1:0] RND = (AW'(1) << K) >> 1;
   localparam logic signed [AW-1:0] MAX = (AW'(1) << (OW - 1)) - AW'(1);
   localparam logic signed [AW-1:0] MIN = ~MAX;

   logic                r_s1_valid, r_out_valid, r_sat;
   logic [1:0]          r_s1_mode;
   logic [SW-1:0]       r_s1_slope;
   logic [N*IW-1:0]     r_s1_x;
   logic [N*OW-1:0]     r_out, w_res;
   logic [N-1:0]        w_sat;
   logic                w_s2_ready, w_in_fire, w_move;

   // every element is brought to the product's fractional scale first, so one rounding path serves all modes
   for (genvar i = 0; i < N; i++) begin : g_el
      logic signed [IW-1:0] w_x;
      logic signed [PW-1:0] w_p, w_v;
      logic signed [AW-1:0] w_a;
      assign w_x = r_s1_x[i*IW +: IW];
      assign w_p = PW'(w_x) * PW'($signed(r_s1_slope));
      assign w_v = (!w_x[IW-1] || r_s1_mode[1]) ? PW'(w_x) <<< SFR : (r_s1_mode[0] ? w_p : '0);
      assign w_a = ((AW'(w_v) + RND) >>> K) <<< L;
      assign w_sat[i] = w_a > MAX || w_a < MIN;
      assign w_res[i*OW +: OW] = w_a > MAX ? MAX[OW-1:0] : (w_a < MIN ? MIN[OW-1:0] : w_a[OW-1:0]);
   end

   assign w_s2_ready      = !r_out_valid || data_out_0_ready;
   assign data_in_0_ready = rst || !r_s1_valid || w_s2_ready;
   assign w_in_fire       = data_in_0_valid && data_in_0_ready;
   assign w_move          = r_s1_valid && w_s2_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid  <= 1'b0;
         r_s1_mode   <= '0;
         r_s1_slope  <= '0;
         r_s1_x      <= '0;
         r_out_valid <= 1'b0;
         r_out       <= '0;
         r_sat       <= 1'b0;
      end else begin
         if (data_in_0_ready) r_s1_valid <= data_in_0_valid;
         if (w_in_fire) begin
            r_s1_x     <= data_in_0;
            r_s1_mode  <= mode;
            r_s1_slope <= slope;
         end
         if (w_s2_ready) r_out_valid <= r_s1_valid;
         if (w_move) r_out <= w_res;
         r_sat <= (w_move && |w_sat) || (r_sat && !sat_clear);
      end
   end

   assign data_out_0       = r_out;
   assign data_out_0_valid = r_out_valid;
   assign sat_sticky       = r_sat;
endmodule

// File: tb/tb_leaky_relu_pipe.sv
// tb_leaky_relu_pipe: random and directed checks of leaky_relu_pipe against a real-arithmetic model
module tb_leaky_relu_pipe;
   typedef struct {
      logic [31:0] e0, e1;
      bit          s0, s1;
   } beat_t;

   logic        clk = 0, rst, sat_clear, in_valid, out_ready = 1, rnd_rdy;
   logic [1:0]  mode;
   logic [7:0]  slope;
   logic [31:0] din, dout0, dout1, prev0;
   logic        in_ready0, in_ready1, ov0, ov1, sat0, sat1;
   int          checks = 0, failures = 0, n_in = 0, n_out = 0, cyc = 0;
   beat_t       q[$];
   bit          started = 0, rst_seen = 0, held = 0, clr_prev = 0, es0 = 0, es1 = 0;

   leaky_relu_pipe d0 (
      .clk(clk), .rst(rst), .mode(mode), .slope(slope), .sat_clear(sat_clear),
      .data_in_0(din), .data_in_0_valid(in_valid), .data_in_0_ready(in_ready0),
      .data_out_0(dout0), .data_out_0_valid(ov0), .data_out_0_ready(out_ready), .sat_sticky(sat0));

   leaky_relu_pipe #(.DATA_OUT_0_PRECISION_1(5)) d1 (
      .clk(clk), .rst(rst), .mode(mode), .slope(slope), .sat_clear(sat_clear),
      .data_in_0(din), .data_in_0_valid(in_valid), .data_in_0_ready(in_ready1),
      .data_out_0(dout1), .data_out_0_valid(ov1), .data_out_0_ready(out_ready), .sat_sticky(sat1));

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;
   always @(posedge clk) begin
      #1;
      out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // value = x/2^4 or x*slope/2^11, scaled to 2^of, rounded half-up, clamped to 8 bits
   function automatic void elem(input int x, input int md, input int sl, input int of, output int r, output bit s);
      real v;
      if (x >= 0 || md >= 2) v = x / 16.0;
      else if (md == 0) v = 0.0;
      else v = (x * sl) / 2048.0;
      v = $floor(v * real'(1 << of) + 0.5);
      s = v > 127.0 || v < -128.0;
      r = v > 127.0 ? 127 : (v < -128.0 ? -128 : $rtoi(v));
   endfunction

   function automatic beat_t model(input logic [31:0] xs, input logic [1:0] md, input logic [7:0] sl);
      beat_t b;
      int r;
      bit s;
      b.s0 = 0;
      b.s1 = 0;
      for (int i = 0; i < 4; i++) begin
         elem($signed(xs[i*8 +: 8]), int'(md), $signed(sl), 4, r, s);
         b.e0[i*8 +: 8] = r[7:0];
         b.s0 |= s;
         elem($signed(xs[i*8 +: 8]), int'(md), $signed(sl), 5, r, s);
         b.e1[i*8 +: 8] = r[7:0];
         b.s1 |= s;
      end
      return b;
   endfunction

   function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
      return {d[7:0], c[7:0], b[7:0], a[7:0]};
   endfunction

   always @(negedge clk) begin
      bit new_show;
      if (started) begin
         if (rst_seen) begin
            es0 = 0;
            es1 = 0;
            chk(!ov0 && !ov1 && dout0 == 0 && dout1 == 0 && !sat0 && !sat1, "reset_state", {ov0, ov1, sat0, sat1}, 0);
         end else begin
            if (held) chk(ov0 && dout0 == prev0, "stall_hold", dout0, prev0);
            new_show = ov0 && !held;
            if (clr_prev) begin
               es0 = 0;
               es1 = 0;
            end
            if (ov0 || ov1) begin
               if (q.size() == 0) chk(0, "spurious_valid", {ov0, ov1}, 0);
               else begin
                  chk(ov0 && ov1, "valid_pair", {ov0, ov1}, 2'b11);
                  chk(dout0 == q[0].e0, "data_of4", dout0, q[0].e0);
                  chk(dout1 == q[0].e1, "data_of5", dout1, q[0].e1);
                  if (new_show) begin
                     es0 |= q[0].s0;
                     es1 |= q[0].s1;
                  end
               end
            end
            chk(sat0 == es0 && sat1 == es1, "sat_sticky", {sat0, sat1}, {es0, es1});
         end
      end
      held = ov0 && !out_ready && !rst;
      prev0 = dout0;
      clr_prev = sat_clear;
      if (rst) begin
         q.delete();
         rst_seen = 1;
         started = 1;
      end else begin
         rst_seen = 0;
         if (ov0 && out_ready && q.size() > 0) begin
            void'(q.pop_front());
            n_out++;
         end
         if (in_valid && in_ready0) begin
            q.push_back(model(din, mode, slope));
            n_in++;
         end
      end
   end

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   // call at posedge+1; returns at posedge+1 right after the accepting edge
   task automatic send(input logic [31:0] xs, input logic [1:0] md, input logic [7:0] sl);
      in_valid = 1;
      din = xs;
      mode = md;
      slope = sl;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (in_ready0) begin
            sync();
            in_valid = 0;
            return;
         end
         sync();
      end
      in_valid = 0;
      chk(0, "send_timeout", 0, 1);
   endtask

   task automatic wait_idle();
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         #1;
         if (q.size() == 0 && !ov0) begin
            sync();
            return;
         end
      end
      chk(0, "idle_timeout", q.size(), 0);
      sync();
   endtask

   initial begin
      int r, c, n;
      bit s, bad;
      logic [31:0] a;
      rst = 1; in_valid = 0; din = 0; mode = 0; slope = 0; sat_clear = 0; rnd_rdy = 0;
      elem(-32, 1, 16, 4, r, s);   chk(r == -4 && !s, "pin_leaky", r, -4);
      elem(-4, 1, 16, 4, r, s);    chk(r == 0 && !s, "pin_tie", r, 0);
      elem(-128, 1, -128, 5, r, s); chk(r == 127 && s, "pin_sat", r, 127);
      elem(-1, 1, -128, 5, r, s);  chk(r == 2 && !s, "pin_negslope", r, 2);
      @(negedge clk);
      chk(in_ready0 && in_ready1, "ready_in_reset", {in_ready0, in_ready1}, 2'b11);
      repeat (2) @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      chk(!ov0 && dout0 == 0 && !sat0, "reset_out", {ov0, sat0, dout0}, 0);
      sync();
      send(pk(-32, -1, -4, 40), 2'd1, 8'd16);
      @(negedge clk);
      chk(!ov0, "lat_early", ov0, 0);
      @(negedge clk);
      chk(ov0, "lat_valid", ov0, 1);
      chk(dout0 == pk(-4, 0, 0, 40), "leaky_of4", dout0, pk(-4, 0, 0, 40));
      chk(dout1 == pk(-8, 0, -1, 80), "leaky_of5", dout1, pk(-8, 0, -1, 80));
      chk(!sat0 && !sat1, "leaky_nosat", {sat0, sat1}, 0);
      sync();
      a = pk(-5, 3, -128, 127);
      send(a, 2'd0, 8'd16);
      send(a, 2'd2, 8'd16);
      @(negedge clk);
      chk(dout0 == pk(0, 3, 0, 127), "relu_beat", dout0, pk(0, 3, 0, 127));
      @(negedge clk);
      chk(dout0 == a, "ident_beat", dout0, a);
      sync();
      sat_clear = 1;
      sync();
      sat_clear = 0;
      @(negedge clk);
      chk(!sat0 && !sat1, "clear", {sat0, sat1}, 0);
      sync();
      a = pk(127, -128, 0, -1);
      send(a, 2'd1, 8'h80);
      @(negedge clk);
      chk(!sat1, "sat_not_yet", sat1, 0);
      @(negedge clk);
      chk(sat1, "sat_set", sat1, 1);
      chk(dout1 == pk(127, 127, 0, 2), "sat_of5", dout1, pk(127, 127, 0, 2));
      chk(dout0 == pk(127, 127, 0, 1), "sat_of4", dout0, pk(127, 127, 0, 1));
      sync();
      sat_clear = 1;
      sync();
      sat_clear = 0;
      @(negedge clk);
      chk(!sat1, "sat_cleared", sat1, 0);
      sync();
      send(a, 2'd1, 8'h80);
      sat_clear = 1;
      sync();
      sat_clear = 0;
      @(negedge clk);
      chk(sat1, "set_wins", sat1, 1);
      sync();
      wait_idle();
      c = cyc;
      n = n_out;
      for (int i = 0; i < 8; i++) send($urandom, 2'($urandom_range(0, 3)), 8'($urandom));
      chk(cyc - c == 8, "tput_in", cyc - c, 8);
      @(negedge clk);
      @(negedge clk);
      #1;
      chk(n_out - n == 8, "tput_out", n_out - n, 8);
      sync();
      rnd_rdy = 1;
      n = n_out;
      for (int i = 0; i < 20; i++) begin
         sat_clear = $urandom_range(0, 7) == 0;
         send($urandom, 2'($urandom_range(0, 3)), 8'($urandom));
         if ($urandom_range(0, 3) == 0) sync();
      end
      sat_clear = 0;
      wait_idle();
      rnd_rdy = 0;
      chk(n_out - n == 20, "rand_count", n_out - n, 20);
      wait_idle();
      send(pk(10, -20, 30, -40), 2'd1, 8'd64);
      send(pk(1, 2, 3, 4), 2'd2, 8'd0);
      rst = 1;
      sync();
      rst = 0;
      @(negedge clk);
      chk(!ov0 && dout0 == 0, "rst_flush", {ov0, dout0}, 0);
      bad = 0;
      repeat (6) begin
         @(negedge clk);
         if (ov0 || ov1) bad = 1;
      end
      chk(!bad, "no_stale", bad, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1);
   end
endmodule
